// File: rtl/flash_cmd_sequencer.sv
// Sequences JEDEC program/erase/reset command cycles onto the shared cartridge flash bus,
// using only m2 cycles the CPU leaves free (romsel=1), then polls DQ7/DQ5 for completion.
module flash_cmd_sequencer #(
    parameter int unsigned          ADDR_W        = 27,
    parameter logic [11:0]          UNLOCK_A      = 12'hAAA,
    parameter logic [11:0]          UNLOCK_B      = 12'h555,
    parameter int unsigned          TIMEOUT_W     = 25,
    parameter logic [TIMEOUT_W-1:0] PROG_TIMEOUT  = TIMEOUT_W'(1024),
    parameter logic [TIMEOUT_W-1:0] ERASE_TIMEOUT = TIMEOUT_W'(18000000)
) (
    input  logic              m2,
    input  logic              reset_n,
    input  logic              romsel,
    input  logic              cmd_start,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_data,
    input  logic [7:0]        flash_dq,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              seq_active,
    output logic [ADDR_W-1:0] seq_addr,
    output logic [7:0]        seq_data,
    output logic              seq_we_n,
    output logic              seq_oe_n
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_POLL, S_RECOVER, S_LAST, S_DONE} state_t;
    typedef enum logic [1:0] {OP_PROG, OP_SECT, OP_CHIP, OP_RST} op_t;

    localparam logic [ADDR_W-1:0] ADDR_A = {{(ADDR_W-12){1'b0}}, UNLOCK_A};
    localparam logic [ADDR_W-1:0] ADDR_B = {{(ADDR_W-12){1'b0}}, UNLOCK_B};

    state_t               state, state_nx;
    op_t                  op_q, op_nx;
    logic [ADDR_W-1:0]    addr_q, addr_nx;
    logic [7:0]           data_q, data_nx;
    logic [2:0]           step, step_nx;
    logic [TIMEOUT_W-1:0] tmo_cnt, tmo_nx;
    logic                 retry, retry_nx;
    logic                 error_q, error_nx;
    logic                 active_q, active_nx;
    logic                 wr_q, wr_nx;
    logic [ADDR_W-1:0]    saddr_q, saddr_nx;
    logic [7:0]           sdata_q, sdata_nx;

    logic [ADDR_W-1:0]    step_addr;
    logic [7:0]           step_data;
    logic                 step_last;
    logic [ADDR_W-1:0]    poll_addr;
    logic                 exp_dq7;
    logic                 dq_match;
    logic                 read_done;
    logic [TIMEOUT_W-1:0] tmo_limit;
    logic                 unused_dq;

    assign poll_addr = (op_q == OP_CHIP) ? '0 : addr_q;
    assign exp_dq7   = (op_q == OP_PROG) ? data_q[7] : 1'b1;
    assign dq_match  = (flash_dq[7] == exp_dq7);
    assign tmo_limit = (op_q == OP_PROG) ? PROG_TIMEOUT : ERASE_TIMEOUT;
    assign read_done = active_q & ~wr_q;
    assign unused_dq = ^{flash_dq[6], flash_dq[4:0]};

    // Unlock prefix is shared by all erase/program ops; the final step is op-specific.
    always_comb begin
        step_addr = ADDR_A;
        step_data = 8'hAA;
        step_last = 1'b0;
        case (step)
            3'd0, 3'd3: ;
            3'd1, 3'd4: begin
                step_addr = ADDR_B;
                step_data = 8'h55;
            end
            3'd2: step_data = (op_q == OP_PROG) ? 8'hA0 : 8'h80;
            default: begin
                step_data = (op_q == OP_CHIP) ? 8'h10 : 8'h30;
                if (op_q != OP_CHIP)
                    step_addr = addr_q;
                step_last = 1'b1;
            end
        endcase
        if (op_q == OP_PROG && step == 3'd3) begin
            step_addr = addr_q;
            step_data = data_q;
            step_last = 1'b1;
        end
        if (op_q == OP_RST) begin
            step_addr = addr_q;
            step_data = 8'hF0;
            step_last = 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        op_nx     = op_q;
        addr_nx   = addr_q;
        data_nx   = data_q;
        step_nx   = step;
        tmo_nx    = tmo_cnt;
        retry_nx  = retry;
        error_nx  = error_q;
        active_nx = 1'b0;
        wr_nx     = wr_q;
        saddr_nx  = saddr_q;
        sdata_nx  = sdata_q;
        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (cmd_start) begin
                    op_nx    = op_t'(cmd_op);
                    addr_nx  = cmd_addr;
                    data_nx  = cmd_data;
                    step_nx  = '0;
                    tmo_nx   = '0;
                    retry_nx = 1'b0;
                    error_nx = 1'b0;
                    state_nx = S_CMD;
                end
            end
            S_CMD: begin
                if (romsel) begin
                    active_nx = 1'b1;
                    wr_nx     = 1'b1;
                    saddr_nx  = step_addr;
                    sdata_nx  = step_data;
                    step_nx   = step + 3'd1;
                    if (step_last)
                        state_nx = (op_q == OP_RST) ? S_LAST : S_POLL;
                end
            end
            S_POLL: begin
                // A read slot that just ended is judged regardless of this edge's romsel.
                if (read_done && dq_match) begin
                    error_nx = 1'b0;
                    state_nx = S_DONE;
                end else if (read_done && (retry || tmo_cnt >= tmo_limit)) begin
                    error_nx = 1'b1;
                    state_nx = S_RECOVER;
                end else begin
                    if (read_done && flash_dq[5])
                        retry_nx = 1'b1;
                    if (romsel) begin
                        active_nx = 1'b1;
                        wr_nx     = 1'b0;
                        saddr_nx  = poll_addr;
                        sdata_nx  = '0;
                        if (tmo_cnt != '1)
                            tmo_nx = tmo_cnt + 1'b1;
                    end
                end
            end
            S_RECOVER: begin
                if (romsel) begin
                    active_nx = 1'b1;
                    wr_nx     = 1'b1;
                    saddr_nx  = addr_q;
                    sdata_nx  = 8'hF0;
                    state_nx  = S_LAST;
                end
            end
            S_LAST:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op_q     <= OP_PROG;
            addr_q   <= '0;
            data_q   <= '0;
            step     <= '0;
            tmo_cnt  <= '0;
            retry    <= 1'b0;
            error_q  <= 1'b0;
            active_q <= 1'b0;
            wr_q     <= 1'b0;
            saddr_q  <= '0;
            sdata_q  <= '0;
        end else begin
            state    <= state_nx;
            op_q     <= op_nx;
            addr_q   <= addr_nx;
            data_q   <= data_nx;
            step     <= step_nx;
            tmo_cnt  <= tmo_nx;
            retry    <= retry_nx;
            error_q  <= error_nx;
            active_q <= active_nx;
            wr_q     <= wr_nx;
            saddr_q  <= saddr_nx;
            sdata_q  <= sdata_nx;
        end
    end

    assign busy       = (state == S_CMD) || (state == S_POLL) || (state == S_RECOVER) || (state == S_LAST);
    assign done       = (state == S_DONE);
    assign error      = error_q;
    assign seq_active = active_q;
    assign seq_addr   = saddr_q;
    assign seq_data   = sdata_q;
    assign seq_we_n   = ~(active_q & wr_q & m2);
    assign seq_oe_n   = ~(active_q & ~wr_q & m2);

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: directed scenarios plus randomized commands checked
// against a list-based model of the expected flash bus operations.
module tb_flash_cmd_sequencer;

    localparam int TB_PROG_TMO  = 8;
    localparam int TB_ERASE_TMO = 16;

    typedef struct packed {
        logic        we;
        logic [26:0] addr;
        logic [7:0]  data;
    } op_s;

    logic        m2, reset_n, romsel, cmd_start;
    logic [1:0]  cmd_op;
    logic [26:0] cmd_addr;
    logic [7:0]  cmd_data, flash_dq;
    logic        busy, done, error, seq_active, seq_we_n, seq_oe_n;
    logic [26:0] seq_addr;
    logic [7:0]  seq_data;

    int checks = 0;
    int passes = 0;

    op_s        obs_q[$];
    op_s        exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] dq_default;
    logic       exp_err, err_obs;
    int         mode;
    bit         spam;
    bit         dropped, finished, acc_ok, post_ok;
    int         proto_bad;

    flash_cmd_sequencer #(
        .ADDR_W(27),
        .PROG_TIMEOUT(25'd8),
        .ERASE_TIMEOUT(25'd16)
    ) dut (
        .m2(m2), .reset_n(reset_n), .romsel(romsel), .cmd_start(cmd_start),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flash_dq(flash_dq),
        .busy(busy), .done(done), .error(error), .seq_active(seq_active),
        .seq_addr(seq_addr), .seq_data(seq_data), .seq_we_n(seq_we_n), .seq_oe_n(seq_oe_n)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    function automatic op_s mk(input logic we, input logic [26:0] a, input logic [7:0] d);
        op_s o;
        o.we = we; o.addr = a; o.data = d;
        return o;
    endfunction

    // Expected bus operations derived from the JEDEC command tables and the poll rules.
    task automatic build_expect(input logic [1:0] op, input logic [26:0] addr, input logic [7:0] data);
        logic [26:0] a = 27'hAAA;
        logic [26:0] b = 27'h555;
        logic [26:0] paddr;
        logic        exp7;
        logic [7:0]  r;
        int          lim, n;
        bit          reread;
        exp_q.delete();
        exp_err = 1'b0;
        if (op == 2'd3) begin
            exp_q.push_back(mk(1'b1, addr, 8'hF0));
            return;
        end
        exp_q.push_back(mk(1'b1, a, 8'hAA));
        exp_q.push_back(mk(1'b1, b, 8'h55));
        if (op == 2'd0) begin
            exp_q.push_back(mk(1'b1, a, 8'hA0));
            exp_q.push_back(mk(1'b1, addr, data));
        end else begin
            exp_q.push_back(mk(1'b1, a, 8'h80));
            exp_q.push_back(mk(1'b1, a, 8'hAA));
            exp_q.push_back(mk(1'b1, b, 8'h55));
            if (op == 2'd1) exp_q.push_back(mk(1'b1, addr, 8'h30));
            else            exp_q.push_back(mk(1'b1, a, 8'h10));
        end
        exp7   = (op == 2'd0) ? data[7] : 1'b1;
        lim    = (op == 2'd0) ? TB_PROG_TMO : TB_ERASE_TMO;
        paddr  = (op == 2'd2) ? 27'd0 : addr;
        n      = 0;
        reread = 0;
        while (n < 100) begin
            r = (n < resp_q.size()) ? resp_q[n] : dq_default;
            n++;
            exp_q.push_back(mk(1'b0, paddr, 8'h00));
            if (r[7] == exp7) break;
            if (reread || n >= lim) begin
                exp_q.push_back(mk(1'b1, addr, 8'hF0));
                exp_err = 1'b1;
                break;
            end
            if (r[5]) reread = 1;
        end
    endtask

    function automatic logic pick_romsel();
        if (mode == 0) return ($urandom_range(0, 9) < 7);
        if (mode == 2 && obs_q.size() == 1 && !dropped) begin
            dropped = 1;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drives one command and records every granted slot; judging is left to the caller.
    task automatic run_cmd(input logic [1:0] op, input logic [26:0] addr, input logic [7:0] data);
        int   cyc = 0;
        int   rd  = 0;
        logic prev_rs;
        obs_q.delete();
        proto_bad = 0; finished = 0; dropped = 0; err_obs = 1'bx;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_start = 1'b1; romsel = 1'b1;
        @(posedge m2); #1;
        cmd_start = 1'b0;
        acc_ok  = (busy === 1'b1 && seq_active === 1'b0 && error === 1'b0 && done === 1'b0);
        romsel  = pick_romsel();
        prev_rs = romsel;
        while (!finished && cyc < 400) begin
            @(posedge m2); #1;
            cyc++;
            if (seq_active === 1'b1) begin
                if (!prev_rs) proto_bad++;
                if ((seq_we_n ^ seq_oe_n) !== 1'b1) proto_bad++;
                obs_q.push_back(mk(~seq_we_n, seq_addr, seq_we_n ? 8'h00 : seq_data));
                if (seq_oe_n === 1'b0) begin
                    flash_dq = (rd < resp_q.size()) ? resp_q[rd] : dq_default;
                    rd++;
                end
            end else if (seq_we_n !== 1'b1 || seq_oe_n !== 1'b1) begin
                proto_bad++;
            end
            if (done === 1'b1) begin
                finished = 1;
                err_obs  = error;
                if (busy !== 1'b0 || seq_active !== 1'b0) proto_bad++;
            end else if (busy !== 1'b1) begin
                proto_bad++;
            end
            cmd_start = (busy === 1'b1) && (spam || $urandom_range(0, 3) == 0);
            cmd_op    = 2'($urandom);
            cmd_addr  = 27'($urandom);
            cmd_data  = 8'($urandom);
            romsel    = pick_romsel();
            prev_rs   = romsel;
        end
        cmd_start = 1'b0;
        @(posedge m2); #1;
        post_ok = (done === 1'b0 && busy === 1'b0 && seq_active === 1'b0);
    endtask

    function automatic int ops_diff();
        int d = 0;
        if (obs_q.size() != exp_q.size()) return 1000 + obs_q.size();
        foreach (exp_q[i])
            if (obs_q[i].we !== exp_q[i].we || obs_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].we && obs_q[i].data !== exp_q[i].data)) d++;
        return d;
    endfunction

    function automatic int count_kind(input logic we);
        int c = 0;
        foreach (obs_q[i]) if (obs_q[i].we === we) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; romsel = 1'b1; cmd_start = 1'b0; cmd_op = '0;
        cmd_addr = '0; cmd_data = '0; flash_dq = '0; spam = 0; mode = 1;
        @(posedge m2); #1;
        checks++;
        if ({busy, done, error, seq_active, seq_we_n, seq_oe_n} !== 6'b000011 || seq_addr !== '0 || seq_data !== '0)
            $display("FAIL reset_vals: got b%b%b%b%b%b%b addr=%h data=%h, want 000011 addr=0 data=0",
                     busy, done, error, seq_active, seq_we_n, seq_oe_n, seq_addr, seq_data);
        else passes++;
        #3 reset_n = 1'b1;
        repeat (2) @(posedge m2);
        #1;
        checks++;
        if ({busy, done, seq_active} !== 3'b000) $display("FAIL reset_idle: busy/done/act=%b%b%b want 000", busy, done, seq_active);
        else passes++;
    endtask

    task automatic test_program();
        resp_q = '{8'h80, 8'h80, 8'h3C}; dq_default = 8'h3C; mode = 1; spam = 0;
        build_expect(2'd0, 27'h012345, 8'h3C);
        run_cmd(2'd0, 27'h012345, 8'h3C);
        checks++;
        if ({acc_ok, finished, proto_bad == 0, post_ok} !== 4'b1111)
            $display("FAIL prog_status: acc/fin/proto/post=%b%b%0d%b want 1,1,0,1", acc_ok, finished, proto_bad, post_ok);
        else passes++;
        checks++;
        if (ops_diff() != 0) $display("FAIL prog_ops: %0d ops (diff %0d), want %0d", obs_q.size(), ops_diff(), exp_q.size());
        else passes++;
        checks++;
        if (count_kind(1'b0) != 3) $display("FAIL prog_reads: got %0d want 3", count_kind(1'b0));
        else passes++;
        checks++;
        if (err_obs !== 1'b0) $display("FAIL prog_error: got %b want 0", err_obs);
        else passes++;
    endtask

    task automatic test_deferral();
        resp_q = '{}; dq_default = 8'h3C; mode = 2; spam = 0;
        build_expect(2'd0, 27'h012345, 8'h3C);
        run_cmd(2'd0, 27'h012345, 8'h3C);
        checks++;
        if ({acc_ok, finished, proto_bad == 0, post_ok, dropped} !== 5'b11111)
            $display("FAIL defer_status: acc/fin/proto/post/drop=%b%b%0d%b%b want 1,1,0,1,1", acc_ok, finished, proto_bad, post_ok, dropped);
        else passes++;
        checks++;
        if (ops_diff() != 0) $display("FAIL defer_ops: %0d ops (diff %0d), want %0d", obs_q.size(), ops_diff(), exp_q.size());
        else passes++;
        checks++;
        if (count_kind(1'b1) != 4) $display("FAIL defer_writes: got %0d want 4", count_kind(1'b1));
        else passes++;
        mode = 1;
    endtask

    task automatic test_dq5_fail();
        resp_q = '{8'h20, 8'h20}; dq_default = 8'h20; mode = 1; spam = 1;
        build_expect(2'd0, 27'h00BEEF, 8'hA5);
        run_cmd(2'd0, 27'h00BEEF, 8'hA5);
        spam = 0;
        checks++;
        if ({acc_ok, finished, proto_bad == 0, post_ok} !== 4'b1111)
            $display("FAIL dq5_status: acc/fin/proto/post=%b%b%0d%b want 1,1,0,1", acc_ok, finished, proto_bad, post_ok);
        else passes++;
        checks++;
        if (ops_diff() != 0) $display("FAIL dq5_ops: %0d ops (diff %0d), want %0d", obs_q.size(), ops_diff(), exp_q.size());
        else passes++;
        checks++;
        if (err_obs !== 1'b1) $display("FAIL dq5_error: got %b want 1", err_obs);
        else passes++;
        repeat (3) @(posedge m2);
        #1;
        checks++;
        if ({error, busy} !== 2'b10) $display("FAIL error_sticky: error/busy=%b%b want 10", error, busy);
        else passes++;
    endtask

    task automatic test_chip_erase();
        resp_q = '{8'h80}; dq_default = 8'h80; mode = 1; spam = 0;
        build_expect(2'd2, 27'h7654321, 8'h00);
        run_cmd(2'd2, 27'h7654321, 8'h00);
        checks++;
        if ({acc_ok, finished, proto_bad == 0, post_ok} !== 4'b1111)
            $display("FAIL chip_status: acc/fin/proto/post=%b%b%0d%b want 1,1,0,1", acc_ok, finished, proto_bad, post_ok);
        else passes++;
        checks++;
        if (ops_diff() != 0) $display("FAIL chip_ops: %0d ops (diff %0d), want %0d", obs_q.size(), ops_diff(), exp_q.size());
        else passes++;
        checks++;
        if (count_kind(1'b1) != 6 || count_kind(1'b0) != 1)
            $display("FAIL chip_counts: writes=%0d reads=%0d want 6 1", count_kind(1'b1), count_kind(1'b0));
        else passes++;
        checks++;
        if (err_obs !== 1'b0) $display("FAIL chip_error: got %b want 0", err_obs);
        else passes++;
    endtask

    task automatic test_sector_timeout();
        resp_q = '{}; dq_default = 8'h00; mode = 1; spam = 0;
        build_expect(2'd1, 27'h040000, 8'h00);
        run_cmd(2'd1, 27'h040000, 8'h00);
        checks++;
        if ({acc_ok, finished, proto_bad == 0, post_ok} !== 4'b1111)
            $display("FAIL tmo_status: acc/fin/proto/post=%b%b%0d%b want 1,1,0,1", acc_ok, finished, proto_bad, post_ok);
        else passes++;
        checks++;
        if (ops_diff() != 0) $display("FAIL tmo_ops: %0d ops (diff %0d), want %0d", obs_q.size(), ops_diff(), exp_q.size());
        else passes++;
        checks++;
        if (count_kind(1'b0) != TB_ERASE_TMO) $display("FAIL tmo_reads: got %0d want %0d", count_kind(1'b0), TB_ERASE_TMO);
        else passes++;
        checks++;
        if (err_obs !== 1'b1) $display("FAIL tmo_error: got %b want 1", err_obs);
        else passes++;
    endtask

    task automatic test_async_reset();
        int grants = 0;
        int cyc    = 0;
        int stray  = 0;
        mode = 1; romsel = 1'b1;
        cmd_op = 2'd0; cmd_addr = 27'h0ABCDE; cmd_data = 8'h5A; cmd_start = 1'b1;
        @(posedge m2); #1;
        cmd_start = 1'b0;
        while (grants < 3 && cyc < 50) begin
            @(posedge m2); #1;
            cyc++;
            if (seq_active === 1'b1) grants++;
        end
        checks++;
        if (grants != 3) $display("FAIL areset_reach: grants=%0d want 3", grants);
        else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, seq_active, seq_we_n, seq_oe_n} !== 6'b000011 || seq_addr !== '0 || seq_data !== '0)
            $display("FAIL areset_vals: got b%b%b%b%b%b%b addr=%h data=%h, want 000011 addr=0 data=0",
                     busy, done, error, seq_active, seq_we_n, seq_oe_n, seq_addr, seq_data);
        else passes++;
        repeat (2) begin
            @(posedge m2); #1;
            if (seq_active !== 1'b0 || busy !== 1'b0) stray++;
        end
        #5 reset_n = 1'b1;
        @(posedge m2); #1;
        checks++;
        if (stray != 0 || seq_active !== 1'b0) $display("FAIL areset_hold: stray=%0d act=%b want 0 0", stray, seq_active);
        else passes++;
        resp_q = '{}; dq_default = 8'h5A;
        build_expect(2'd0, 27'h0ABCDE, 8'h5A);
        run_cmd(2'd0, 27'h0ABCDE, 8'h5A);
        checks++;
        if ({acc_ok, finished, proto_bad == 0, post_ok} !== 4'b1111 || ops_diff() != 0)
            $display("FAIL areset_after: acc/fin/proto/post=%b%b%0d%b ops=%0d diff=%0d", acc_ok, finished, proto_bad, post_ok, obs_q.size(), ops_diff());
        else passes++;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [26:0] addr;
        logic [7:0]  data;
        logic        exp7;
        mode = 0;
        for (int it = 0; it < 12; it++) begin
            op   = 2'($urandom);
            addr = 27'($urandom);
            data = 8'($urandom);
            spam = ($urandom_range(0, 1) == 1);
            exp7 = (op == 2'd0) ? data[7] : 1'b1;
            resp_q.delete();
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) resp_q.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) dq_default = {exp7, 7'($urandom)};
            else                           dq_default = {~exp7, 1'($urandom), 1'b0, 5'($urandom)};
            build_expect(op, addr, data);
            run_cmd(op, addr, data);
            checks++;
            if ({acc_ok, finished, proto_bad == 0, post_ok} !== 4'b1111)
                $display("FAIL rand%0d_status: op=%0d acc/fin/proto/post=%b%b%0d%b want 1,1,0,1", it, op, acc_ok, finished, proto_bad, post_ok);
            else passes++;
            checks++;
            if (ops_diff() != 0)
                $display("FAIL rand%0d_ops: op=%0d %0d ops (diff %0d), want %0d", it, op, obs_q.size(), ops_diff(), exp_q.size());
            else passes++;
            checks++;
            if (err_obs !== exp_err) $display("FAIL rand%0d_error: op=%0d got %b want %b", it, op, err_obs, exp_err);
            else passes++;
        end
        spam = 0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_deferral();
        test_dq5_fail();
        test_chip_erase();
        test_sector_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
